// File: rtl/four_bit_serial_subtractor_pkg.sv
// four_bit_serial_subtractor_pkg: shared widths and FSM encoding for the bit-serial subtractor
package four_bit_serial_subtractor_pkg;
    localparam int WIDTH = 4;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/fullSubtractor.sv
// fullSubtractor: one-bit combinational subtract stage, d = a - b - bin with borrow out
module fullSubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/four_bit_serial_subtractor.sv
// four_bit_serial_subtractor: computes A - B - Bin one bit per cycle, LSB first, through a single full subtractor
module four_bit_serial_subtractor
    import four_bit_serial_subtractor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin,
    output logic       D0,
    output logic       D1,
    output logic       D2,
    output logic       D3,
    output logic       Bo,
    output logic       busy,
    output logic       done
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
    logic               br_q, br_d, bo_q, bo_d;
    logic               diff, bout;
    fullSubtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (diff),
        .bout (bout)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        d_d     = d_q;
        bo_d    = bo_q;
        unique case (state_q)
            IDLE: if (start) begin
                a_d     = A;
                b_d     = B;
                br_d    = Bin;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Difference bits enter from the MSB so the LSB ends up at bit 0 after four shifts
                res_d = {diff, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    d_d     = res_d;
                    bo_d    = bout;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            d_q     <= '0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
        end
    end
    assign {D3, D2, D1, D0} = d_q;
    assign Bo   = bo_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
endmodule
